// File: rtl/tapsum_mac_serial.sv
// Serial MAC stage for the symmetric 15-tap FIR.
// It captures the eight folded tap sums on a sample strobe and accumulates
// sum(tap*coef) on one multiplier over eight cycles. The sum is then rounded
// half up, shifted, and saturated into filter_out.
module tapsum_mac_serial #(
  parameter int COEF_W = 10,
  parameter int ACC_W  = 22,
  parameter int SHIFT  = 6,
  parameter int OUT_W  = 16,
  parameter logic signed [COEF_W-1:0] COEF0 = COEF_W'(-3),
  parameter logic signed [COEF_W-1:0] COEF1 = COEF_W'(-8),
  parameter logic signed [COEF_W-1:0] COEF2 = COEF_W'(12),
  parameter logic signed [COEF_W-1:0] COEF3 = COEF_W'(41),
  parameter logic signed [COEF_W-1:0] COEF4 = COEF_W'(89),
  parameter logic signed [COEF_W-1:0] COEF5 = COEF_W'(141),
  parameter logic signed [COEF_W-1:0] COEF6 = COEF_W'(180),
  parameter logic signed [COEF_W-1:0] COEF7 = COEF_W'(190)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic [8:0]       tapsum_mcand,
  input  logic [8:0]       tapsum_mcand_1,
  input  logic [8:0]       tapsum_mcand_2,
  input  logic [8:0]       tapsum_mcand_3,
  input  logic [8:0]       tapsum_mcand_4,
  input  logic [8:0]       tapsum_mcand_5,
  input  logic [8:0]       tapsum_mcand_6,
  input  logic [7:0]       tapsum_mcand_7,
  input  logic             ovr_clr,
  output logic [OUT_W-1:0] filter_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  // Rounding constant (half an output LSB) and the output saturation limits.
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'((64'sd1 <<< SHIFT) >>> 1);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  state_t                  state, state_nxt;
  logic [7:0][8:0]         cap;
  logic [2:0]              idx;
  logic signed [ACC_W-1:0] acc;
  logic [8:0]              cap_sel;
  logic [COEF_W-1:0]       coef_sel;
  logic [ACC_W-1:0]        prod;
  logic signed [ACC_W-1:0] rnd_sum, shifted;
  logic [OUT_W-1:0]        sat;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. MAC runs for idx = 0..7, which is exactly eight edges.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (clk_enable) state_nxt = MAC;
      MAC:     if (idx == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore output: busy is a decode of the state register, so it is glitch-free.
  always_comb begin
    busy = (state != IDLE);
  end

  // Select the coefficient and captured tap sum for the current MAC step.
  always_comb begin
    cap_sel = cap[idx];
    unique case (idx)
      3'd0:    coef_sel = COEF0;
      3'd1:    coef_sel = COEF1;
      3'd2:    coef_sel = COEF2;
      3'd3:    coef_sel = COEF3;
      3'd4:    coef_sel = COEF4;
      3'd5:    coef_sel = COEF5;
      3'd6:    coef_sel = COEF6;
      default: coef_sel = COEF7;
    endcase
  end

  // Sign-extend both operands to ACC_W. The low ACC_W bits of the unsigned
  // product then equal the signed product, because ACC_W holds it exactly.
  always_comb begin
    prod = {{(ACC_W-9){cap_sel[8]}}, cap_sel} *
           {{(ACC_W-COEF_W){coef_sel[COEF_W-1]}}, coef_sel};
  end

  // Round half up, arithmetic shift, then clamp to the signed OUT_W range.
  always_comb begin
    rnd_sum = acc + RND;
    shifted = rnd_sum >>> SHIFT;
    if (shifted > MAXV)      sat = MAXV[OUT_W-1:0];
    else if (shifted < MINV) sat = MINV[OUT_W-1:0];
    else                     sat = shifted[OUT_W-1:0];
  end

  // Datapath: capture on strobe, accumulate in MAC, publish in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap        <= '0;
      acc        <= '0;
      idx        <= '0;
      filter_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= (state == DONE);
      unique case (state)
        IDLE: if (clk_enable) begin
          cap <= {{tapsum_mcand_7[7], tapsum_mcand_7}, tapsum_mcand_6, tapsum_mcand_5,
                  tapsum_mcand_4, tapsum_mcand_3, tapsum_mcand_2, tapsum_mcand_1,
                  tapsum_mcand};
          acc <= '0;
          idx <= '0;
        end
        MAC: begin
          acc <= acc + $signed(prod);
          idx <= idx + 3'd1;
        end
        DONE:    filter_out <= sat;
        default: ;
      endcase
    end
  end

  // Sticky overrun flag. A strobe dropped while busy wins over a clear on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             overrun <= 1'b0;
    else if (clk_enable && state != IDLE)  overrun <= 1'b1;
    else if (ovr_clr)                      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_tapsum_mac_serial.sv
// Directed bench for tapsum_mac_serial using a scoreboard of expected outputs.
// Two instances share the stimulus: one uses the default SHIFT=6 and one uses SHIFT=0,
// which exercises saturation.
module tb_tapsum_mac_serial;

  logic        clk = 1'b0;
  logic        reset, clk_enable, ovr_clr;
  logic [8:0]  t0, t1, t2, t3, t4, t5, t6;
  logic [7:0]  t7;
  logic [15:0] filter_out, filter_out0;
  logic        out_valid, busy, overrun, out_valid0, busy0, overrun0;

  int errors = 0;
  int checks = 0;
  int q[$];
  int q0[$];
  int tv[8];
  int coef[8] = '{-3, -8, 12, 41, 89, 141, 180, 190};

  always #5 clk = ~clk;

  tapsum_mac_serial dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .tapsum_mcand(t0), .tapsum_mcand_1(t1), .tapsum_mcand_2(t2), .tapsum_mcand_3(t3),
    .tapsum_mcand_4(t4), .tapsum_mcand_5(t5), .tapsum_mcand_6(t6), .tapsum_mcand_7(t7),
    .ovr_clr(ovr_clr), .filter_out(filter_out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun));

  tapsum_mac_serial #(.SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .tapsum_mcand(t0), .tapsum_mcand_1(t1), .tapsum_mcand_2(t2), .tapsum_mcand_3(t3),
    .tapsum_mcand_4(t4), .tapsum_mcand_5(t5), .tapsum_mcand_6(t6), .tapsum_mcand_7(t7),
    .ovr_clr(ovr_clr), .filter_out(filter_out0), .out_valid(out_valid0),
    .busy(busy0), .overrun(overrun0));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: full-precision dot product, round half up, shift, saturate to 16 bits.
  function automatic int model(input int t[8], input int sh);
    int acc;
    acc = 0;
    for (int i = 0; i < 8; i++) acc += t[i] * coef[i];
    acc = (acc + ((1 << sh) >>> 1)) >>> sh;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic drive_taps();
    t0 = tv[0][8:0]; t1 = tv[1][8:0]; t2 = tv[2][8:0]; t3 = tv[3][8:0];
    t4 = tv[4][8:0]; t5 = tv[5][8:0]; t6 = tv[6][8:0]; t7 = tv[7][7:0];
  endtask

  task automatic fill(input int v, input int c);
    for (int i = 0; i < 7; i++) tv[i] = v;
    tv[7] = c;
  endtask

  // Strobe accepted at the next edge; push the expected result for both instances.
  task automatic strobe_push();
    drive_taps();
    q.push_back(model(tv, 6));
    q0.push_back(model(tv, 0));
    clk_enable = 1'b1;
    @(posedge clk); #1;
    clk_enable = 1'b0;
  endtask

  // Called #1 after the strobe edge T: walks edges T+1..T+9 and checks the handshake timing.
  task automatic lat_check(input string tag);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      chk({tag, "_valid"}, int'(out_valid), int'(k == 9));
      chk({tag, "_busy"},  int'(busy),      int'(k != 9));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  // Compare every output sample with the head of the scoreboard.
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $error("FAIL unexpected_valid observed=1 expected=0");
      end else chk("filter_out", int'($signed(filter_out)), q.pop_front());
    end
    if (out_valid0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $error("FAIL unexpected_valid0 observed=1 expected=0");
      end else chk("filter_out0", int'($signed(filter_out0)), q0.pop_front());
    end
  end

  initial begin
    reset = 1'b1; clk_enable = 1'b0; ovr_clr = 1'b0;
    fill(0, 0); drive_taps();
    repeat (2) @(posedge clk); #1;
    chk("rst_filter_out", int'(filter_out), 0);
    chk("rst_valid",      int'(out_valid),  0);
    chk("rst_busy",       int'(busy),       0);
    chk("rst_overrun",    int'(overrun),    0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Unit taps: acc=642, giving 10 at SHIFT=6. Out_valid is a single pulse after edge T+9.
    fill(1, 1);
    strobe_push();
    lat_check("lat1");
    @(posedge clk); #1;
    chk("valid_single_pulse", int'(out_valid), 0);

    // Most negative taps: -2188, and -32768 after saturation at SHIFT=0.
    fill(-256, -128);
    strobe_push();
    wait_idle();

    // Most positive taps: acc=139390, which saturates to 32767 at SHIFT=0.
    fill(255, 127);
    strobe_push();
    wait_idle();

    // A strobe at T+4 is dropped and the result comes from the first sample only.
    tv = '{10, -20, 30, -40, 50, -60, 70, -80};
    strobe_push();
    repeat (3) @(posedge clk);
    #1;
    fill(100, 100); drive_taps();
    clk_enable = 1'b1;
    @(posedge clk); #1;
    clk_enable = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    wait_idle();
    @(posedge clk); #1;

    // A clear on the same edge as a dropped strobe leaves overrun set; a lone clear then clears it.
    strobe_push();
    clk_enable = 1'b1; ovr_clr = 1'b1;
    @(posedge clk); #1;
    clk_enable = 1'b0; ovr_clr = 1'b0;
    chk("overrun_set_wins", int'(overrun), 1);
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    chk("overrun_clear", int'(overrun), 0);
    wait_idle();
    @(posedge clk); #1;

    // Assert reset mid-cycle during MAC. Outputs drop at once and the sample is abandoned.
    tv = '{-7, 13, -100, 200, -255, 120, 33, -90};
    strobe_push();
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_filter_out", int'(filter_out), 0);
    chk("async_busy",       int'(busy),       0);
    chk("async_valid",      int'(out_valid),  0);
    chk("async_overrun",    int'(overrun),    0);
    void'(q.pop_back());
    void'(q0.pop_back());
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tv = '{-7, 13, -100, 200, -255, 120, 33, -90};
    strobe_push();
    lat_check("lat_after_rst");

    // Back-to-back strobes every 10 cycles; the first one lands in the out_valid cycle.
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 7; i++) tv[i] = int'($urandom_range(0, 511)) - 256;
      tv[7] = int'($urandom_range(0, 255)) - 128;
      strobe_push();
      repeat (9) @(posedge clk);
      #1;
    end
    wait_idle();
    chk("b2b_overrun", int'(overrun), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty",  q.size(),  0);
    chk("scoreboard0_empty", q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
